// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM state encoding (BOOT / RUN / HALT)
//   IF_ADDR_W     : default instruction word-address width
//   IF_DATA_W     : default instruction width
//   NOP_WORD      : all-zero word; unprogrammed memory reads back as this
package instr_fetch_stage_pkg;

  localparam int IF_ADDR_W = 8;
  localparam int IF_DATA_W = 32;
  localparam logic [IF_DATA_W-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_stage_pc_reg.sv
// Program counter register with load / increment / hold.
//   clk, rst_n : clock, async active-low reset (pc <- RESET_PC)
//   load       : take load_pc next cycle (highest priority)
//   load_pc    : load target
//   inc        : pc <- pc + 1, wrapping at 2^ADDR_W
//   pc         : current program counter
module instr_fetch_stage_pc_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter int ADDR_W   = IF_ADDR_W,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= ADDR_W'(RESET_PC);
    else if (load) pc <= load_pc;
    else if (inc)  pc <= pc + ADDR_W'(1);
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, addresses a combinational instruction memory and
// presents fetched words on a valid/ready IF/ID register.
//   clk, rst_n        : clock, async active-low reset
//   imem_addr         : word address to memory (= pc)
//   imem_rdata        : instruction at imem_addr, same cycle
//   redirect_valid/pc : branch/jump target; flushes IF/ID, wins over all else
//   id_ready          : decode accepts id_* this cycle
//   id_valid/instr/pc : IF/ID register contents
//   id_pc_plus1       : id_pc + 1 (wrapping)
//   halted            : FSM is in HALT
//   fetch_count       : instructions accepted by decode, saturating
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int ADDR_W       = IF_ADDR_W,
  parameter int DATA_W       = IF_DATA_W,
  parameter int RESET_PC     = 0,
  parameter bit HALT_ON_ZERO = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus1,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_e      state, state_nxt;
  logic              advance, halt_hit, pc_inc;
  logic [ADDR_W-1:0] pc;

  instr_fetch_stage_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redirect_valid),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    advance   = (state == ST_RUN) && (!id_valid || id_ready);
    // A zero word ends the program: it is swallowed, pc parks on it.
    halt_hit  = advance && HALT_ON_ZERO && (imem_rdata == DATA_W'(NOP_WORD));
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN:  if (halt_hit) state_nxt = ST_HALT;
      default: state_nxt = state;
    endcase
    if (redirect_valid) state_nxt = ST_RUN;
    pc_inc = advance && !halt_hit && !redirect_valid;
  end

  // IF/ID register. On flush/halt only the valid bit drops; payload is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
    end else if (advance) begin
      id_valid <= !halt_hit;
      if (!halt_hit) begin
        id_instr <= imem_rdata;
        id_pc    <= pc;
      end
    end else if (id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
  end

  // A handshake coinciding with a redirect is flushed, so it is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= '0;
    else if (id_valid && id_ready && !redirect_valid && (fetch_count != '1))
      fetch_count <= fetch_count + CNT_W'(1);
  end

  assign imem_addr   = pc;
  assign id_pc_plus1 = id_pc + ADDR_W'(1);
  assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem [256];

  // main DUT (halt on zero word)
  logic [7:0]  imem_addr, redirect_pc, id_pc, id_pc_plus1;
  logic [31:0] imem_rdata, id_instr;
  logic        redirect_valid, id_ready, id_valid, halted;
  logic [15:0] fetch_count;

  // second DUT (no halt on zero) for the wrap case
  logic [7:0]  addr2, rpc2, pc2, plus1_2;
  logic [31:0] rdata2, instr2;
  logic        redir2, ready2, valid2, halted2;
  logic [15:0] cnt2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];
  assign rdata2     = mem[addr2];

  instr_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus1(id_pc_plus1),
    .halted(halted), .fetch_count(fetch_count)
  );

  instr_fetch_stage #(.HALT_ON_ZERO(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_addr(addr2), .imem_rdata(rdata2),
    .redirect_valid(redir2), .redirect_pc(rpc2), .id_ready(ready2),
    .id_valid(valid2), .id_instr(instr2), .id_pc(pc2), .id_pc_plus1(plus1_2),
    .halted(halted2), .fetch_count(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [7:0]  rpc;
    logic        v;
    logic [7:0]  pc;
    logic        h;
    logic [7:0]  addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rdy, logic redir, logic [7:0] rpc, logic v,
                              logic [7:0] pc, logic h, logic [7:0] addr, logic [15:0] cnt);
    vec_t t;
    t.rdy = rdy; t.redir = redir; t.rpc = rpc; t.v = v;
    t.pc = pc; t.h = h; t.addr = addr; t.cnt = cnt;
    return t;
  endfunction

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // program at 0..11, rest zero
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h20010003; mem[1]  = 32'h20020009; mem[2]  = 32'h20030002;
    mem[3]  = 32'h20040004; mem[4]  = 32'h20050005; mem[5]  = 32'h20060006;
    mem[6]  = 32'h20070007; mem[7]  = 32'h200100CA; mem[8]  = 32'h20080008;
    mem[9]  = 32'h20090009; mem[10] = 32'h200A000A; mem[11] = 32'h200B000B;

    //          rdy redir rpc  v  pc  h  addr cnt
    tbl.push_back(mk(1, 0, 0,   0, 0,  0, 0,  0));  // BOOT bubble
    tbl.push_back(mk(1, 0, 0,   1, 0,  0, 1,  0));
    tbl.push_back(mk(1, 0, 0,   1, 1,  0, 2,  1));
    tbl.push_back(mk(1, 0, 0,   1, 2,  0, 3,  2));
    tbl.push_back(mk(0, 0, 0,   1, 2,  0, 3,  2));  // stall x3 at pc2
    tbl.push_back(mk(0, 0, 0,   1, 2,  0, 3,  2));
    tbl.push_back(mk(0, 0, 0,   1, 2,  0, 3,  2));
    tbl.push_back(mk(1, 0, 0,   1, 3,  0, 4,  3));
    tbl.push_back(mk(1, 0, 0,   1, 4,  0, 5,  4));
    tbl.push_back(mk(0, 0, 0,   1, 4,  0, 5,  4));  // stall at pc4
    tbl.push_back(mk(0, 1, 7,   0, 0,  0, 7,  4));  // redirect to 7
    tbl.push_back(mk(1, 0, 0,   1, 7,  0, 8,  4));
    tbl.push_back(mk(1, 0, 0,   1, 8,  0, 9,  5));
    tbl.push_back(mk(1, 0, 0,   1, 9,  0, 10, 6));
    tbl.push_back(mk(1, 0, 0,   1, 10, 0, 11, 7));
    tbl.push_back(mk(1, 0, 0,   1, 11, 0, 12, 8));
    tbl.push_back(mk(1, 0, 0,   0, 0,  1, 12, 9));  // zero word -> HALT
    tbl.push_back(mk(1, 0, 0,   0, 0,  1, 12, 9));
    tbl.push_back(mk(1, 1, 0,   0, 0,  0, 0,  9));  // redirect out of HALT
    tbl.push_back(mk(1, 0, 0,   1, 0,  0, 1,  9));
    tbl.push_back(mk(1, 0, 0,   1, 1,  0, 2,  10));

    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ready2 = 1'b1; redir2 = 1'b0; rpc2 = '0;
    #12;
    chk("rst id_valid", 32'(id_valid), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst count", 32'(fetch_count), 0);
    chk("rst addr", 32'(imem_addr), 0);
    chk("rst id_instr", id_instr, 0);
    chk("rst id_pc", 32'(id_pc), 0);
    #2 rst_n = 1'b1;   // released between edges

    foreach (tbl[i]) begin
      id_ready = tbl[i].rdy; redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
      tick();
      chk($sformatf("row%0d valid", i), 32'(id_valid), 32'(tbl[i].v));
      chk($sformatf("row%0d addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d halted", i), 32'(halted), 32'(tbl[i].h));
      chk($sformatf("row%0d count", i), 32'(fetch_count), 32'(tbl[i].cnt));
      if (tbl[i].v) begin
        chk($sformatf("row%0d id_pc", i), 32'(id_pc), 32'(tbl[i].pc));
        chk($sformatf("row%0d instr", i), id_instr, mem[tbl[i].pc]);
        chk($sformatf("row%0d plus1", i), 32'(id_pc_plus1), 32'(tbl[i].pc + 8'd1));
      end
    end
    id_ready = 1'b1; redirect_valid = 1'b0;

    // async reset mid-stream, then full program run
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(id_valid), 0);
    chk("async rst count", 32'(fetch_count), 0);
    chk("async rst addr", 32'(imem_addr), 0);
    chk("async rst halted", 32'(halted), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("restart bubble", 32'(id_valid), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("run%0d valid", i), 32'(id_valid), 1);
      chk($sformatf("run%0d id_pc", i), 32'(id_pc), 32'(i));
      chk($sformatf("run%0d instr", i), id_instr, mem[i]);
    end
    tick();
    chk("end halted", 32'(halted), 1);
    chk("end valid", 32'(id_valid), 0);
    chk("end count", 32'(fetch_count), 12);
    chk("end addr", 32'(imem_addr), 12);
    tick();
    chk("end addr frozen", 32'(imem_addr), 12);

    // wrap 255 -> 0 on the non-halting instance
    redir2 = 1'b1; rpc2 = 8'd255;
    tick();
    redir2 = 1'b0;
    chk("wrap flush valid", 32'(valid2), 0);
    chk("wrap addr", 32'(addr2), 255);
    tick();
    chk("wrap valid", 32'(valid2), 1);
    chk("wrap id_pc", 32'(pc2), 255);
    chk("wrap plus1", 32'(plus1_2), 0);
    chk("wrap next addr", 32'(addr2), 0);
    chk("wrap no halt", 32'(halted2), 0);
    tick();
    chk("wrap refetch", instr2, mem[0]);

    // randomized run against a stream-level model:
    // decode must see pc, pc+1, ... from the last redirect target, stopping at a zero word.
    begin
      logic [7:0]  exp_pc;
      int          exp_cnt;
      logic        prev_stall;
      logic [7:0]  prev_pc;
      logic [31:0] prev_instr;
      rst_n = 1'b0; #2 rst_n = 1'b1;
      exp_pc = 8'd0; exp_cnt = 0; prev_stall = 1'b0; prev_pc = '0; prev_instr = '0;
      for (int c = 0; c < 2000; c++) begin
        tick();
        chk("rnd count", 32'(fetch_count), 32'(exp_cnt));
        if (halted) chk("rnd halt addr", 32'(imem_addr), 32'(exp_pc));
        if (prev_stall) begin
          chk("rnd stall valid", 32'(id_valid), 1);
          chk("rnd stall pc", 32'(id_pc), 32'(prev_pc));
          chk("rnd stall instr", id_instr, prev_instr);
        end
        id_ready       = ($urandom % 4) != 0;
        redirect_valid = ($urandom % 12) == 0;
        redirect_pc    = ($urandom % 8 == 0) ? 8'd255 : 8'($urandom_range(0, 13));
        if (redirect_valid) begin
          exp_pc = redirect_pc;
        end else if (id_valid && id_ready) begin
          chk("rnd accept pc", 32'(id_pc), 32'(exp_pc));
          chk("rnd accept instr", id_instr, mem[exp_pc]);
          exp_pc  = exp_pc + 8'd1;
          exp_cnt = exp_cnt + 1;
        end
        prev_stall = id_valid && !id_ready && !redirect_valid;
        prev_pc    = id_pc;
        prev_instr = id_instr;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
